// File: rtl/ariane_pkg.sv
// Shared definitions for the return-address guard: CFI fault cause, tag bit position
// and the committed control-flow record.
package ariane_pkg;

  // Default virtual address width of the core
  localparam int unsigned RET_VLEN = 32;

  // Encoded link values carry this tag bit set
  localparam int unsigned RET_TAG_BIT = RET_VLEN - 1;

  // Exception cause raised toward the exception path on a return-address mismatch
  localparam logic [31:0] CFI_FAULT = 32'd18;

  // One committed control-flow instruction
  typedef struct packed {
    logic                valid;
    logic                call;
    logic                ret;
    logic [RET_VLEN-1:0] link;
    logic [RET_VLEN-1:0] target;
  } ret_commit_t;

endpackage

// File: rtl/ret_addr_stack.sv
// Circular shadow return stack. When full, a push overwrites the oldest entry and sets the
// sticky overflow flag; a pop on an empty stack clears that flag.
module ret_addr_stack #(
  parameter int unsigned VLEN  = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [VLEN-1:0]          data_i,
  output logic [VLEN-1:0]          top_o,
  output logic [$clog2(DEPTH):0]   depth_o,
  output logic                     overflow_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = 1;
  localparam logic [PW:0]   CNT_ONE = 1;
  localparam logic [PW:0]   CNT_FULL = DEPTH[PW:0];

  logic [VLEN-1:0] mem_q [DEPTH];
  logic [PW-1:0]   sp_q, sp_d, top_idx, wr_idx;
  logic [PW:0]     cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic            empty, full, do_pop, wr_en;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CNT_FULL);
  assign do_pop  = pop_i && !empty;
  // sp_q is the next write slot, so the live top sits one below it
  assign top_idx = sp_q - PTR_ONE;
  assign top_o   = mem_q[top_idx];

  // Next-state for pointer, count and overflow; pop-then-push reuses the top slot
  always_comb begin
    sp_d   = sp_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    wr_en  = 1'b0;
    wr_idx = sp_q;
    if (pop_i && empty) begin
      ovf_d = 1'b0;
    end
    if (do_pop && push_i) begin
      wr_en  = 1'b1;
      wr_idx = top_idx;
    end else if (do_pop) begin
      sp_d  = top_idx;
      cnt_d = cnt_q - CNT_ONE;
    end else if (push_i) begin
      wr_en = 1'b1;
      sp_d  = sp_q + PTR_ONE;
      if (full) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  // Control state; reset discards all entries at once
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  // Entry storage, validity is tracked by cnt_q alone
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wr_idx] <= data_i;
    end
  end

  assign depth_o    = cnt_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/ret_addr_guard.sv
// Return-address guard: XOR-key encode of call links, decode of return targets, and a
// committed shadow stack that flags mismatching returns.
// Shadow stack and fault logic exist only when RET_ADDR_GUARD_SHADOW_STACK_EN is defined.
module ret_addr_guard
  import ariane_pkg::*;
#(
  parameter int unsigned     VLEN      = RET_VLEN,
  parameter int unsigned     DEPTH     = 8,
  parameter logic [VLEN-2:0] RESET_KEY = 'h73fa06c2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   ex_call_i,
  input  logic                   ex_ret_i,
  input  logic [VLEN-1:0]        ex_next_pc_i,
  input  logic [VLEN-1:0]        ex_target_i,
  output logic [VLEN-1:0]        link_o,
  output logic [VLEN-1:0]        target_o,
  input  logic                   commit_valid_i,
  input  logic                   commit_call_i,
  input  logic                   commit_ret_i,
  input  logic [VLEN-1:0]        commit_link_i,
  input  logic [VLEN-1:0]        commit_target_i,
  input  logic [VLEN-2:0]        key_i,
  input  logic                   key_valid_i,
  output logic                   key_ready_o,
  output logic                   cfi_fault_o,
  output logic [VLEN-1:0]        fault_addr_o,
  output logic [$clog2(DEPTH):0] depth_o,
  output logic                   overflow_o
);

  logic [VLEN-2:0] key_q;
  logic            key_load;

  // EX encode/decode against the key registered before this cycle
  always_comb begin
    link_o = ex_next_pc_i;
    if (ex_call_i) begin
      link_o = {1'b1, ex_next_pc_i[VLEN-2:0] ^ key_q};
    end
    target_o = ex_target_i;
    if (ex_ret_i || ex_target_i[VLEN-1]) begin
      target_o = {1'b0, ex_target_i[VLEN-2:0] ^ key_q};
    end
  end

  assign key_load = key_valid_i && key_ready_o;

  // Key register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      key_q <= RESET_KEY;
    end else if (key_load) begin
      key_q <= key_i;
    end
  end

`ifdef RET_ADDR_GUARD_SHADOW_STACK_EN
  logic                   push, pop, fault_d;
  logic [VLEN-1:0]        top;
  logic [$clog2(DEPTH):0] depth;
  logic                   overflow;
  logic                   fault_q;
  logic [VLEN-1:0]        fault_addr_q;

  assign push = commit_valid_i && commit_call_i;
  assign pop  = commit_valid_i && commit_ret_i;

  ret_addr_stack #(
    .VLEN  (VLEN),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push_i     (push),
    .pop_i      (pop),
    .data_i     (commit_link_i),
    .top_o      (top),
    .depth_o    (depth),
    .overflow_o (overflow)
  );

  // A return on an empty stack is only trusted if entries were lost to overflow
  always_comb begin
    fault_d = 1'b0;
    if (pop) begin
      fault_d = (depth != '0) ? (top != commit_target_i) : !overflow;
    end
  end

  // Registered one-cycle fault pulse with the offending target held until the next fault
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      fault_q <= fault_d;
      if (fault_d) begin
        fault_addr_q <= commit_target_i;
      end
    end
  end

  assign cfi_fault_o  = fault_q;
  assign fault_addr_o = fault_addr_q;
  assign depth_o      = depth;
  assign overflow_o   = overflow;
  // Rekeying with live links would orphan them
  assign key_ready_o  = (depth == '0);
`else
  logic unused_commit;
  assign unused_commit = ^{commit_valid_i, commit_call_i, commit_ret_i,
                           commit_link_i, commit_target_i};

  assign cfi_fault_o  = 1'b0;
  assign fault_addr_o = '0;
  assign depth_o      = '0;
  assign overflow_o   = 1'b0;
  assign key_ready_o  = 1'b1;
`endif

endmodule

// File: tb/tb_ret_addr_guard.sv
// Directed bench for ret_addr_guard; covers the shadow stack when
// RET_ADDR_GUARD_SHADOW_STACK_EN is defined, otherwise the EX path and key only.
module tb_ret_addr_guard;

  logic        clk, rst_n;
  logic        ex_call, ex_ret;
  logic [31:0] ex_next_pc, ex_target, link, target;
  logic        commit_valid, commit_call, commit_ret;
  logic [31:0] commit_link, commit_target;
  logic [30:0] key;
  logic        key_valid, key_ready;
  logic        cfi_fault;
  logic [31:0] fault_addr;
  logic [3:0]  depth;
  logic        overflow;

  int vectors;
  int miscompares;

  ret_addr_guard #(
    .VLEN      (32),
    .DEPTH     (8),
    .RESET_KEY (31'h73fa06c2)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .ex_call_i       (ex_call),
    .ex_ret_i        (ex_ret),
    .ex_next_pc_i    (ex_next_pc),
    .ex_target_i     (ex_target),
    .link_o          (link),
    .target_o        (target),
    .commit_valid_i  (commit_valid),
    .commit_call_i   (commit_call),
    .commit_ret_i    (commit_ret),
    .commit_link_i   (commit_link),
    .commit_target_i (commit_target),
    .key_i           (key),
    .key_valid_i     (key_valid),
    .key_ready_o     (key_ready),
    .cfi_fault_o     (cfi_fault),
    .fault_addr_o    (fault_addr),
    .depth_o         (depth),
    .overflow_o      (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Return 1 ns after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One commit cycle, then idle the commit inputs
  task automatic commit(input logic c, input logic r, input logic [31:0] l,
                        input logic [31:0] t);
    commit_valid  = 1'b1;
    commit_call   = c;
    commit_ret    = r;
    commit_link   = l;
    commit_target = t;
    tick();
    commit_valid  = 1'b0;
    commit_call   = 1'b0;
    commit_ret    = 1'b0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    ex_call = 1'b0; ex_ret = 1'b0; ex_next_pc = '0; ex_target = '0;
    commit_valid = 1'b0; commit_call = 1'b0; commit_ret = 1'b0;
    commit_link = '0; commit_target = '0;
    key = '0; key_valid = 1'b0;

    #1;
    chk("rst_depth", {28'b0, depth}, 32'd0);
    chk("rst_overflow", {31'b0, overflow}, 32'd0);
    chk("rst_fault", {31'b0, cfi_fault}, 32'd0);
    chk("rst_fault_addr", fault_addr, 32'd0);
    chk("rst_key_ready", {31'b0, key_ready}, 32'd1);
    #11;
    rst_n = 1'b1;
    tick();

    // EX path with reset key 0x73fa06c2
    ex_call = 1'b1; ex_next_pc = 32'h0000_1004; ex_target = 32'h0000_0040;
    #1;
    chk("call_encode", link, 32'hF3FA_16C6);
    chk("plain_target", target, 32'h0000_0040);
    ex_call = 1'b0;
    #1;
    chk("noncall_link", link, 32'h0000_1004);
    ex_ret = 1'b1; ex_target = 32'hF3FA_16C6;
    #1;
    chk("ret_decode", target, 32'h0000_1004);
    ex_target = 32'h0000_1004;
    #1;
    chk("ret_decode_untagged", target, 32'h73FA_16C6);
    ex_ret = 1'b0; ex_target = 32'h8000_0000;
    #1;
    chk("tag_decode", target, 32'h73FA_06C2);
    ex_target = '0;

`ifdef RET_ADDR_GUARD_SHADOW_STACK_EN
    // Matching call/return
    commit(1'b1, 1'b0, 32'h1004, 32'h0);
    chk("push_depth", {28'b0, depth}, 32'd1);
    chk("push_key_ready", {31'b0, key_ready}, 32'd0);
    commit(1'b0, 1'b1, 32'h0, 32'h1004);
    chk("match_fault", {31'b0, cfi_fault}, 32'd0);
    chk("match_depth", {28'b0, depth}, 32'd0);

    // Mismatching return
    commit(1'b1, 1'b0, 32'h1004, 32'h0);
    commit(1'b0, 1'b1, 32'h0, 32'h2000);
    chk("mismatch_fault", {31'b0, cfi_fault}, 32'd1);
    chk("mismatch_addr", fault_addr, 32'h2000);
    tick();
    chk("fault_pulse_end", {31'b0, cfi_fault}, 32'd0);

    // Overflow: 9 pushes into 8 entries
    for (int i = 0; i < 9; i++) commit(1'b1, 1'b0, 32'h100 + 32'(i) * 4, 32'h0);
    chk("ovf_depth", {28'b0, depth}, 32'd8);
    chk("ovf_flag", {31'b0, overflow}, 32'd1);
    for (int i = 8; i >= 1; i--) begin
      commit(1'b0, 1'b1, 32'h0, 32'h100 + 32'(i) * 4);
      chk("ovf_pop_fault", {31'b0, cfi_fault}, 32'd0);
    end
    chk("ovf_drained_depth", {28'b0, depth}, 32'd0);
    commit(1'b0, 1'b1, 32'h0, 32'h0);
    chk("ovf_extra_fault", {31'b0, cfi_fault}, 32'd0);
    chk("ovf_cleared", {31'b0, overflow}, 32'd0);
    commit(1'b0, 1'b1, 32'h0, 32'h44);
    chk("empty_ret_fault", {31'b0, cfi_fault}, 32'd1);
    chk("empty_ret_addr", fault_addr, 32'h44);

    // Key handshake blocked while a link is live
    commit(1'b1, 1'b0, 32'h500, 32'h0);
    key = 31'h1234_5678; key_valid = 1'b1;
    #1;
    chk("key_blocked", {31'b0, key_ready}, 32'd0);
    tick();
    ex_call = 1'b1; ex_next_pc = 32'h0;
    #1;
    chk("key_unchanged", link, 32'hF3FA_06C2);
    commit(1'b0, 1'b1, 32'h0, 32'h500);
    chk("key_ready_after_pop", {31'b0, key_ready}, 32'd1);
    tick();
    key_valid = 1'b0;
    #1;
    chk("new_key_link", link, 32'h9234_5678);
    ex_call = 1'b0;

    // Simultaneous call + return at depth 3
    commit(1'b1, 1'b0, 32'hA0, 32'h0);
    commit(1'b1, 1'b0, 32'hA4, 32'h0);
    commit(1'b1, 1'b0, 32'hA8, 32'h0);
    commit(1'b1, 1'b1, 32'hB0, 32'hA8);
    chk("swap_fault", {31'b0, cfi_fault}, 32'd0);
    chk("swap_depth", {28'b0, depth}, 32'd3);
    commit(1'b0, 1'b1, 32'h0, 32'hB0);
    chk("swap_new_top", {31'b0, cfi_fault}, 32'd0);
    commit(1'b0, 1'b1, 32'h0, 32'hA4);
    chk("swap_next_top", {31'b0, cfi_fault}, 32'd0);
    chk("swap_depth_after", {28'b0, depth}, 32'd1);

    // Reset mid-operation at depth 5
    for (int i = 0; i < 4; i++) commit(1'b1, 1'b0, 32'hC0 + 32'(i) * 4, 32'h0);
    chk("pre_reset_depth", {28'b0, depth}, 32'd5);
`else
    // Disabled stack: commits are ignored and the key is always writable
    commit(1'b1, 1'b0, 32'h1004, 32'h0);
    chk("nostk_depth", {28'b0, depth}, 32'd0);
    chk("nostk_key_ready", {31'b0, key_ready}, 32'd1);
    commit(1'b0, 1'b1, 32'h0, 32'h2000);
    chk("nostk_fault", {31'b0, cfi_fault}, 32'd0);
    chk("nostk_overflow", {31'b0, overflow}, 32'd0);
    key = 31'h1234_5678; key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    ex_call = 1'b1; ex_next_pc = 32'h0;
    #1;
    chk("nostk_new_key_link", link, 32'h9234_5678);
    ex_call = 1'b0;
`endif

    // Asynchronous reset restores the key and empties the stack
    #2;
    rst_n = 1'b0;
    ex_call = 1'b1; ex_next_pc = 32'h0000_1004;
    #1;
    chk("reset_depth", {28'b0, depth}, 32'd0);
    chk("reset_key_link", link, 32'hF3FA_16C6);
    chk("reset_key_ready", {31'b0, key_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_reset_depth", {28'b0, depth}, 32'd0);
    ex_call = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
